// File: rtl/bf16_adder_if.sv
// Operand/result bundle for the bf16 adder.
// The master drives operands and observes results; the slave is the adder itself.
interface bf16_adder_if;
    logic       valid_i;
    logic       sa_i;
    logic [7:0] ea_i;
    logic [6:0] ma_i;
    logic       sb_i;
    logic [7:0] eb_i;
    logic [6:0] mb_i;
    logic       valid_o;
    logic       s_o;
    logic [7:0] e_o;
    logic [6:0] m_o;

    modport master (
        output valid_i, sa_i, ea_i, ma_i, sb_i, eb_i, mb_i,
        input  valid_o, s_o, e_o, m_o
    );

    modport slave (
        input  valid_i, sa_i, ea_i, ma_i, sb_i, eb_i, mb_i,
        output valid_o, s_o, e_o, m_o
    );
endinterface

// File: rtl/bf16_adder.sv
// bf16 adder: combinational align/add/normalize/round-to-nearest-even, one register stage.
// Define BF16_DENORM_EN to keep subnormal operands and results instead of flushing them.
module bf16_adder (
    input  logic        clk,
    input  logic        rst,
    bf16_adder_if.slave bus
);
    logic              a_nan, b_nan, a_inf, b_inf;
    logic [7:0]        a_e, b_e, el, es, d;
    logic [7:0]        a_sig, b_sig, gl, gs;
    logic              sl, ss, swap, eff_sub;
    logic [17:0]       bal;
    logic [9:0]        bsh;
    logic              bst;
    logic [11:0]       sum12;
    logic [10:0]       mn;
    logic [3:0]        lz;
    logic signed [9:0] en;
    logic [8:0]        m9;
    logic [6:0]        mr;
    logic              rup, uf;
    logic              res_s;
    logic [7:0]        res_e;
    logic [6:0]        res_m;
`ifdef BF16_DENORM_EN
    logic [21:0]       dsh;
    logic [9:0]        damt;
`endif

    always_comb begin
        a_nan = (bus.ea_i == 8'hff) && (bus.ma_i != 7'd0);
        b_nan = (bus.eb_i == 8'hff) && (bus.mb_i != 7'd0);
        a_inf = (bus.ea_i == 8'hff) && (bus.ma_i == 7'd0);
        b_inf = (bus.eb_i == 8'hff) && (bus.mb_i == 7'd0);
`ifdef BF16_DENORM_EN
        a_e   = (bus.ea_i == 8'd0) ? 8'd1 : bus.ea_i;
        b_e   = (bus.eb_i == 8'd0) ? 8'd1 : bus.eb_i;
        a_sig = {bus.ea_i != 8'd0, bus.ma_i};
        b_sig = {bus.eb_i != 8'd0, bus.mb_i};
`else
        a_e   = bus.ea_i;
        b_e   = bus.eb_i;
        a_sig = (bus.ea_i == 8'd0) ? 8'd0 : {1'b1, bus.ma_i};
        b_sig = (bus.eb_i == 8'd0) ? 8'd0 : {1'b1, bus.mb_i};
`endif
        swap = {b_e, b_sig} > {a_e, a_sig};
        sl   = swap ? bus.sb_i : bus.sa_i;
        ss   = swap ? bus.sa_i : bus.sb_i;
        el   = swap ? b_e : a_e;
        es   = swap ? a_e : b_e;
        gl   = swap ? b_sig : a_sig;
        gs   = swap ? a_sig : b_sig;

        // Smaller operand keeps guard/round in bsh[1:0]; everything below folds into sticky.
        d   = el - es;
        bal = {gs, 10'd0} >> d;
        if (d > 8'd10) begin
            bsh = 10'd0;
            bst = |gs;
        end else begin
            bsh = bal[17:8];
            bst = |bal[7:0];
        end

        eff_sub = sl ^ ss;
        if (eff_sub)
            sum12 = {1'b0, gl, 3'b000} - {1'b0, bsh, bst};
        else
            sum12 = {1'b0, gl, 3'b000} + {1'b0, bsh, bst};

        en = signed'({2'b00, el});
        if (sum12[11]) begin
            mn = {sum12[11:2], |sum12[1:0]};
            en = en + 10'sd1;
        end else begin
            mn = sum12[10:0];
        end

        lz = 4'd0;
        for (int i = 0; i < 11; i++)
            if (mn[i]) lz = 4'(10 - i);
        mn = mn << lz;
        en = en - signed'({6'd0, lz});

`ifdef BF16_DENORM_EN
        damt = 10'd0;
        dsh  = 22'd0;
        if (en <= 10'sd0) begin
            damt = unsigned'(10'sd1 - en);
            dsh  = {mn, 11'd0} >> damt;
            mn   = {dsh[21:12], |dsh[11:0]};
            en   = 10'sd0;
        end
`endif

        rup = mn[2] & (mn[1] | mn[0] | mn[3]);
        m9  = {1'b0, mn[10:3]} + {8'd0, rup};
        if (m9[8]) begin
            mr = m9[7:1];
            en = en + 10'sd1;
        end else begin
            mr = m9[6:0];
        end

`ifdef BF16_DENORM_EN
        if (en == 10'sd0 && m9[7])
            en = 10'sd1;
        uf = 1'b0;
`else
        uf = (en <= 10'sd0);
`endif

        res_s = sl;
        res_e = en[7:0];
        res_m = mr;
        if (a_nan || b_nan || (a_inf && b_inf && (bus.sa_i != bus.sb_i))) begin
            res_s = 1'b0;
            res_e = 8'hff;
            res_m = 7'h40;
        end else if (a_inf || b_inf) begin
            res_s = a_inf ? bus.sa_i : bus.sb_i;
            res_e = 8'hff;
            res_m = 7'd0;
        end else if (gl == 8'd0) begin
            res_s = bus.sa_i & bus.sb_i;
            res_e = 8'd0;
            res_m = 7'd0;
        end else if (sum12 == 12'd0) begin
            res_s = 1'b0;
            res_e = 8'd0;
            res_m = 7'd0;
        end else if (en >= 10'sd255) begin
            res_e = 8'hff;
            res_m = 7'd0;
        end else if (uf) begin
            res_e = 8'd0;
            res_m = 7'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.valid_o <= 1'b0;
            bus.s_o     <= 1'b0;
            bus.e_o     <= 8'd0;
            bus.m_o     <= 7'd0;
        end else begin
            bus.valid_o <= bus.valid_i;
            if (bus.valid_i) begin
                bus.s_o <= res_s;
                bus.e_o <= res_e;
                bus.m_o <= res_m;
            end
        end
    end
endmodule

// File: tb/tb_bf16_adder.sv
// Bench for bf16_adder: directed vector table, stream/reset sequences, and random
// operands checked against a real-arithmetic reference (honours BF16_DENORM_EN).
module tb_bf16_adder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bf16_adder_if bus_if ();
    bf16_adder dut (.clk(clk), .rst(rst), .bus(bus_if.slave));

    int n_pass  = 0;
    int n_total = 0;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] r;
    } vec_t;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] want);
        n_total++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, want);
    endtask

    task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b);
        bus_if.valid_i = v;
        bus_if.sa_i    = a[15];
        bus_if.ea_i    = a[14:7];
        bus_if.ma_i    = a[6:0];
        bus_if.sb_i    = b[15];
        bus_if.eb_i    = b[14:7];
        bus_if.mb_i    = b[6:0];
    endtask

    function automatic logic [15:0] dout();
        return {bus_if.s_o, bus_if.e_o, bus_if.m_o};
    endfunction

    function automatic logic [15:0] vout();
        return {15'd0, bus_if.valid_o};
    endfunction

    function automatic real to_real(input logic [15:0] x);
        int  e, m;
        real v;
        e = int'(x[14:7]);
        m = int'(x[6:0]);
        if (e == 0) begin
`ifdef BF16_DENORM_EN
            v = m * 2.0 ** real'(-133);
`else
            v = 0.0;
`endif
        end else begin
            v = (128 + m) * 2.0 ** real'(e - 134);
        end
        return x[15] ? -v : v;
    endfunction

    // Exact sum in double precision, then rounded to bf16 nearest-even.
    function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
        logic a_nan, b_nan, a_inf, b_inf, sg;
        real  va, vb, s, x, sc, fr;
        int   e, ex, q;
        a_nan = (a[14:7] == 8'hff) && (a[6:0] != 7'd0);
        b_nan = (b[14:7] == 8'hff) && (b[6:0] != 7'd0);
        a_inf = (a[14:7] == 8'hff) && (a[6:0] == 7'd0);
        b_inf = (b[14:7] == 8'hff) && (b[6:0] == 7'd0);
        if (a_nan || b_nan || (a_inf && b_inf && a[15] != b[15])) return 16'h7fc0;
        if (a_inf) return a;
        if (b_inf) return b;
        va = to_real(a);
        vb = to_real(b);
        if (va == 0.0 && vb == 0.0) return {a[15] & b[15], 15'd0};
        s = va + vb;
        if (s == 0.0) return 16'h0000;
        sg = (s < 0.0);
        x  = sg ? -s : s;
        e  = 0;
        while (x >= 2.0 ** real'(e + 1)) e++;
        while (x < 2.0 ** real'(e)) e--;
        ex = e + 127;
        if (ex >= 255) return {sg, 8'hff, 7'd0};
        if (ex >= 1) begin
            sc = x / (2.0 ** real'(e - 7));
            q  = $rtoi(sc);
            fr = sc - q;
            if (fr > 0.5 || (fr == 0.5 && (q % 2) == 1)) q++;
            if (q == 256) begin
                q = 128;
                ex++;
            end
            if (ex >= 255) return {sg, 8'hff, 7'd0};
            return {sg, 8'(ex), 7'(q - 128)};
        end
`ifdef BF16_DENORM_EN
        sc = x / (2.0 ** real'(-133));
        q  = $rtoi(sc);
        fr = sc - q;
        if (fr > 0.5 || (fr == 0.5 && (q % 2) == 1)) q++;
        if (q >= 128) return {sg, 8'd1, 7'(q - 128)};
        return {sg, 8'd0, 7'(q)};
`else
        return {sg, 15'd0};
`endif
    endfunction

    function automatic logic [15:0] rnd_op(input int near);
        int         r, t;
        logic [7:0] e;
        logic [6:0] m;
        r = int'($urandom_range(0, 19));
        m = 7'($urandom);
        if (r == 0) begin
            e = 8'h00;
            if ($urandom_range(0, 3) == 0) m = 7'd0;
        end else if (r == 1) begin
            e = 8'hff;
            if ($urandom_range(0, 1) == 0) m = 7'd0;
        end else if (r < 12) begin
            t = near + int'($urandom_range(0, 24)) - 12;
            if (t < 1) t = 1;
            if (t > 254) t = 254;
            e = 8'(t);
        end else begin
            e = 8'($urandom_range(1, 254));
        end
        return {1'($urandom), e, m};
    endfunction

    initial begin
        vec_t        vecs[$];
        logic [15:0] exp_d, a, b;
        logic        v;
        int          near;

        vecs.push_back('{16'h0000, 16'h0000, 16'h0000});
        vecs.push_back('{16'h8000, 16'h8000, 16'h8000});
        vecs.push_back('{16'h8000, 16'h0000, 16'h0000});
        vecs.push_back('{16'h3F80, 16'h3F80, 16'h4000});
        vecs.push_back('{16'h3FC0, 16'h3E80, 16'h3FE0});
        vecs.push_back('{16'h3F80, 16'hBF80, 16'h0000});
        vecs.push_back('{16'h4040, 16'hBF80, 16'h4000});
        vecs.push_back('{16'h3F80, 16'h3B80, 16'h3F80});
        vecs.push_back('{16'h3F81, 16'h3B80, 16'h3F82});
        vecs.push_back('{16'h3F80, 16'h3BC0, 16'h3F81});
        vecs.push_back('{16'h3F80, 16'h3300, 16'h3F80});
        vecs.push_back('{16'h3F80, 16'hBB80, 16'h3F7F});
        vecs.push_back('{16'h3F80, 16'hB300, 16'h3F80});
        vecs.push_back('{16'h7F7F, 16'h7F7F, 16'h7F80});
        vecs.push_back('{16'h7F80, 16'hFF80, 16'h7FC0});
        vecs.push_back('{16'h7FC1, 16'h3F80, 16'h7FC0});
        vecs.push_back('{16'hFF80, 16'h3F80, 16'hFF80});
`ifdef BF16_DENORM_EN
        vecs.push_back('{16'h0001, 16'h0001, 16'h0002});
        vecs.push_back('{16'h0080, 16'h8001, 16'h007F});
`else
        vecs.push_back('{16'h0001, 16'h0001, 16'h0000});
        vecs.push_back('{16'h0080, 16'h8001, 16'h0080});
`endif

        rst = 1'b1;
        drive(1'b0, 16'h0000, 16'h0000);
        repeat (2) @(negedge clk);
        check("reset_valid", vout(), 16'd0);
        check("reset_data", dout(), 16'h0000);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].a, vecs[i].b);
            @(negedge clk);
            check($sformatf("vec%0d_valid", i), vout(), 16'd1);
            check($sformatf("vec%0d %h+%h", i, vecs[i].a, vecs[i].b), dout(), vecs[i].r);
        end
        exp_d = vecs[vecs.size() - 1].r;
        drive(1'b0, 16'h1234, 16'h5678);
        @(negedge clk);
        check("idle_valid", vout(), 16'd0);
        check("idle_hold", dout(), exp_d);

        // Four back-to-back operations, then a bubble with junk operands.
        drive(1'b1, 16'h3F80, 16'h3F80);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("stream%0d_valid", k), vout(), 16'd1);
            case (k)
                0: begin check("stream0", dout(), 16'h4000); drive(1'b1, 16'h3FC0, 16'h3E80); end
                1: begin check("stream1", dout(), 16'h3FE0); drive(1'b1, 16'h4040, 16'hBF80); end
                2: begin check("stream2", dout(), 16'h4000); drive(1'b1, 16'h3F81, 16'h3B80); end
                default: begin check("stream3", dout(), 16'h3F82); drive(1'b0, 16'hFFFF, 16'hFFFF); end
            endcase
        end
        @(negedge clk);
        check("stream_end_valid", vout(), 16'd0);
        check("stream_end_hold", dout(), 16'h3F82);

        // Asynchronous reset arriving between clock edges mid-stream.
        drive(1'b1, 16'h3F80, 16'h3F80);
        @(negedge clk);
        drive(1'b1, 16'h7F7F, 16'h7F7F);
        @(posedge clk);
        #1;
        check("pre_rst_valid", vout(), 16'd1);
        check("pre_rst_data", dout(), 16'h7F80);
        #1 rst = 1'b1;
        #1;
        check("async_rst_valid", vout(), 16'd0);
        check("async_rst_data", dout(), 16'h0000);
        @(negedge clk);
        check("in_rst_valid", vout(), 16'd0);
        check("in_rst_data", dout(), 16'h0000);
        drive(1'b0, 16'h3F80, 16'h3F80);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_valid", vout(), 16'd0);
        check("post_rst_data", dout(), 16'h0000);
        drive(1'b1, 16'h3FC0, 16'h3E80);
        @(negedge clk);
        check("first_after_rst_valid", vout(), 16'd1);
        check("first_after_rst_data", dout(), 16'h3FE0);
        exp_d = 16'h3FE0;

        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 3))
                0: near = int'($urandom_range(1, 12));
                1: near = int'($urandom_range(243, 254));
                default: near = int'($urandom_range(1, 254));
            endcase
            v = ($urandom_range(0, 9) != 0);
            a = rnd_op(near);
            b = rnd_op(near);
            if ($urandom_range(0, 15) == 0) b = a ^ 16'h8000;
            drive(v, a, b);
            if (v) exp_d = ref_add(a, b);
            @(negedge clk);
            check($sformatf("rnd%0d_valid", n), vout(), {15'd0, v});
            check($sformatf("rnd%0d %h+%h", n, a, b), dout(), exp_d);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
